// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: words queue in a small circular FIFO and are
// serialised as start / data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  input  logic                  Stop_Bits,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  Tx_OUT,
  output logic                  Busy,
  output logic                  Full,
  output logic                  Overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [BIT_W-1:0]   BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pe_q, pt_q, sb_q;
  logic [PRESC_W-1:0]    presc_q, presc_cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic                  push, pop, fifo_empty, cell_end, stop_done, line_bit;

  always_comb begin
    fifo_empty = (count == '0);
    push       = Data_Valid && !Full;
    cell_end   = (presc_cnt == presc_q - PRESC_ONE);
    // With two stop bits the first stop cell (bit_idx 0) does not end the frame.
    stop_done  = (state == S_STOP) && cell_end && !(sb_q && (bit_idx == '0));
    pop        = !fifo_empty && ((state == S_IDLE) || stop_done);
    count_nxt  = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (!push && pop)
      count_nxt = count - CNT_ONE;
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = data_q[bit_idx];
      S_PARITY: line_bit = (^data_q) ^ pt_q;
      default:  line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push && RST)
      mem[wr_ptr] <= P_Data;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Full    <= 1'b0;
      Overrun <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      Full    <= (count_nxt == CNT_FULL);
      Overrun <= Data_Valid && Full;
      Busy    <= (state != S_IDLE) || !fifo_empty;
    end
  end

  // Tx_OUT registers the cell value of the current state, so the line trails
  // the FSM by one clock.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      presc_cnt <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      pe_q      <= 1'b0;
      pt_q      <= 1'b0;
      sb_q      <= 1'b0;
      presc_q   <= PRESC_ONE;
      Tx_OUT    <= 1'b1;
    end else begin
      Tx_OUT <= line_bit;
      if (state == S_IDLE || cell_end)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESC_ONE;
      if (pop) begin
        data_q  <= mem[rd_ptr];
        pe_q    <= Parity_Enable;
        pt_q    <= Parity_Type;
        sb_q    <= Stop_Bits;
        presc_q <= (Prescale == '0) ? PRESC_ONE : Prescale;
        bit_idx <= '0;
      end
      case (state)
        S_IDLE:   if (pop) state <= S_START;
        S_START:  if (cell_end) begin
                    bit_idx <= '0;
                    state   <= S_DATA;
                  end
        S_DATA:   if (cell_end) begin
                    if (bit_idx == BIT_LAST) begin
                      bit_idx <= '0;
                      state   <= pe_q ? S_PARITY : S_STOP;
                    end else begin
                      bit_idx <= bit_idx + BIT_ONE;
                    end
                  end
        S_PARITY: if (cell_end) begin
                    bit_idx <= '0;
                    state   <= S_STOP;
                  end
        S_STOP:   if (cell_end) begin
                    if (!stop_done)
                      bit_idx <= BIT_ONE;
                    else
                      state <= pop ? S_START : S_IDLE;
                  end
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: hand-computed line patterns per bit
// cell, FIFO full/overrun timing, mid-frame config changes and reset abort.
module tb_uart_tx_fifo_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Parity_Enable;
  logic       Parity_Type;
  logic       Stop_Bits;
  logic [7:0] Prescale;
  logic       Tx_OUT;
  logic       Busy;
  logic       Full;
  logic       Overrun;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_q[$];
  logic [7:0] words [6];

  uart_tx_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .Parity_Enable(Parity_Enable), .Parity_Type(Parity_Type),
    .Stop_Bits(Stop_Bits), .Prescale(Prescale), .Tx_OUT(Tx_OUT),
    .Busy(Busy), .Full(Full), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] d);
    Data_Valid = 1'b1;
    P_Data     = d;
    step();
    Data_Valid = 1'b0;
  endtask

  // Edge after the push: FSM loads, line still idle, Busy already high.
  task automatic latency_check(input string tag);
    step();
    chk({tag, "_lat_tx"}, {31'd0, Tx_OUT}, 32'd1);
    chk({tag, "_busy_rise"}, {31'd0, Busy}, 32'd1);
  endtask

  // exp holds n cells, first cell in bit n-1; each cell is checked every clock for p clocks.
  task automatic check_cells(input string tag, input logic [31:0] exp, input int n, input int p);
    for (int c = 0; c < n; c++)
      for (int j = 0; j < p; j++) begin
        step();
        chk(tag, {31'd0, Tx_OUT}, {31'd0, exp[n-1-c]});
      end
  endtask

  task automatic idle_check(input string tag);
    step();
    chk({tag, "_busy_fall"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_idle_tx"}, {31'd0, Tx_OUT}, 32'd1);
  endtask

  initial begin
    RST = 1'b0; P_Data = '0; Data_Valid = 1'b0; Parity_Enable = 1'b0;
    Parity_Type = 1'b0; Stop_Bits = 1'b0; Prescale = 8'd1;
    step();
    step();
    chk("rst_tx", {31'd0, Tx_OUT}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_full", {31'd0, Full}, 32'd0);
    chk("rst_ovr", {31'd0, Overrun}, 32'd0);
    RST = 1'b1;
    step();

    // 1: plain 8N1, P=1
    push(8'hA5);
    latency_check("t1");
    check_cells("t1_frame", 32'b0101001011, 10, 1);
    idle_check("t1");

    // 1b: Prescale 0 behaves as 1
    Prescale = 8'd0;
    push(8'hA5);
    latency_check("t1b");
    check_cells("t1b_frame", 32'b0101001011, 10, 1);
    idle_check("t1b");
    Prescale = 8'd1;

    // 2: parity even / odd
    Parity_Enable = 1'b1; Parity_Type = 1'b0;
    push(8'hA5);
    latency_check("t2e");
    check_cells("t2_even", 32'b01010010101, 11, 1);
    idle_check("t2e");
    Parity_Type = 1'b1;
    push(8'hA5);
    latency_check("t2o");
    check_cells("t2_odd", 32'b01010010111, 11, 1);
    idle_check("t2o");
    Parity_Type = 1'b0;
    push(8'h07);
    latency_check("t2p");
    check_cells("t2_07_even", 32'b01110000011, 11, 1);
    idle_check("t2p");

    // 3: P=4, two stop bits, 44-clock frame
    Parity_Enable = 1'b0; Stop_Bits = 1'b1; Prescale = 8'd4;
    push(8'h3C);
    latency_check("t3");
    check_cells("t3_frame", 32'b00011110011, 11, 4);
    idle_check("t3");

    // 4: six consecutive pushes into a 4-deep FIFO
    Stop_Bits = 1'b0; Prescale = 8'd1;
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'h5A; words[5] = 8'h33;
    exp_q.delete();
    for (int w = 0; w < 5; w++) begin
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(words[w][b]);
      exp_q.push_back(1'b1);
    end
    for (int c = 1; c <= 52; c++) begin
      if (c <= 6) begin
        Data_Valid = 1'b1;
        P_Data     = words[c-1];
      end else begin
        Data_Valid = 1'b0;
      end
      step();
      if (c >= 3) chk("t4_stream", {31'd0, Tx_OUT}, {31'd0, exp_q.pop_front()});
      if (c == 4)  chk("t4_full_pre", {31'd0, Full}, 32'd0);
      if (c == 5)  chk("t4_full_set", {31'd0, Full}, 32'd1);
      if (c == 5)  chk("t4_ovr_pre", {31'd0, Overrun}, 32'd0);
      if (c == 6)  chk("t4_ovr_pulse", {31'd0, Overrun}, 32'd1);
      if (c == 7)  chk("t4_ovr_end", {31'd0, Overrun}, 32'd0);
      if (c == 11) chk("t4_full_hold", {31'd0, Full}, 32'd1);
      if (c == 12) chk("t4_full_clr", {31'd0, Full}, 32'd0);
      if (c == 30) chk("t4_busy_mid", {31'd0, Busy}, 32'd1);
    end
    idle_check("t4");

    // 5: config changes mid-frame only affect the next frame
    Prescale = 8'd2; Parity_Enable = 1'b0; Parity_Type = 1'b0;
    push(8'h55);
    push(8'h0F);
    Prescale = 8'd5; Parity_Enable = 1'b1;
    check_cells("t5_old_cfg", 32'b0101010101, 10, 2);
    check_cells("t5_new_cfg", 32'b01111000001, 11, 5);
    idle_check("t5");

    // 6: reset during DATA aborts frame and empties FIFO
    Prescale = 8'd3; Parity_Enable = 1'b0; Stop_Bits = 1'b0;
    push(8'hC3);
    push(8'h81);
    for (int i = 0; i < 5; i++) step();
    RST = 1'b0;
    step();
    chk("t6_rst_tx", {31'd0, Tx_OUT}, 32'd1);
    chk("t6_rst_busy", {31'd0, Busy}, 32'd0);
    chk("t6_rst_full", {31'd0, Full}, 32'd0);
    chk("t6_rst_ovr", {31'd0, Overrun}, 32'd0);
    RST = 1'b1;
    step();
    chk("t6_post_busy", {31'd0, Busy}, 32'd0);
    push(8'h96);
    latency_check("t6");
    check_cells("t6_frame", 32'b0011010011, 10, 3);
    idle_check("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
